pwm_multi: RTL and testbench

Multi-channel PWM generator; parametrised successor to the single-channel 12-bit PWM. One shared timebase with programmable prescaler, period and edge- or center-aligned counting drives CHANNELS comparators. Each channel has a glitch-free shadow duty register committed only at period boundaries. It sits between the register/control logic and the motor/LED drive pins.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_timebase.sv | 113 +++++++++++
 rtl/pwm_multi.sv | 99 +++++++++
 tb/tb_pwm_multi.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block and its register logic.
package pwm_pkg;

  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Channel-index width never collapses to zero, even for a single channel.
  function automatic int ch_idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up/up-down counter, config latches and period markers.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int RESOLUTION = 12,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  enable_i,
  input  logic                  mode_i,
  input  logic [RESOLUTION-1:0] period_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [RESOLUTION-1:0] count_o,
  output logic                  commit_o,
  output logic                  period_o
);

  localparam logic [RESOLUTION-1:0] CNT_ONE   = RESOLUTION'(1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [RESOLUTION-1:0] cnt_q, cnt_d;
  logic [RESOLUTION-1:0] period_q, period_d;
  logic                  mode_q, mode_d;
  pwm_dir_e              dir_q, dir_d;
  logic                  start_q, start_d;
  logic                  pulse_q, pulse_d;
  logic                  tick;
  logic                  wrap;

  // start_q marks that the counter register holds the first count of a new
  // period; the pulse is issued one clock later so it lines up with out_o.
  always_comb begin
    presc_d    = presc_q;
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    start_d    = 1'b0;
    pulse_d    = 1'b0;
    wrap       = 1'b0;
    tick       = (presc_q == prescale_q);

    if (!enable_i) begin
      presc_d = '0;
      cnt_d   = '0;
      dir_d   = DIR_UP;
      start_d = 1'b1;
    end else begin
      pulse_d = start_q;
      if (tick) begin
        presc_d = '0;
        if (mode_q == PWM_MODE_CENTER && period_q != '0) begin
          if (dir_q == DIR_UP && cnt_q < period_q) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            dir_d = DIR_DOWN;
          end
        end else if (cnt_q >= period_q) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        wrap = (cnt_d == '0);
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end

    if (wrap) begin
      dir_d   = DIR_UP;
      start_d = 1'b1;
    end

    // New configuration only takes effect where a period begins.
    if (wrap || !enable_i) begin
      period_d   = period_i;
      mode_d     = mode_i;
      prescale_d = prescale_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      presc_q    <= '0;
      prescale_q <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      mode_q     <= PWM_MODE_EDGE;
      dir_q      <= DIR_UP;
      start_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      start_q    <= start_d;
      pulse_q    <= pulse_d;
    end
  end

  assign count_o  = cnt_q;
  assign commit_o = wrap | ~enable_i;
  assign period_o = pulse_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared timebase, per-channel shadow/active duty and comparator.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int RESOLUTION = 12,
  parameter int PRESCALE_W = 8,
  localparam int CH_W      = ch_idx_width(CHANNELS)
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  enable_i,
  input  logic                  mode_i,
  input  logic [RESOLUTION-1:0] period_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  wr_en_i,
  input  logic [CH_W-1:0]       wr_ch_i,
  input  logic [RESOLUTION-1:0] wr_duty_i,
  output logic [CHANNELS-1:0]   out_o,
  output logic                  period_o,
  output logic                  pending_o
);

  logic [RESOLUTION-1:0] count;
  logic                  commit;
  logic                  wr_valid;
  logic [CHANNELS-1:0]   out_q, out_d;
  logic                  pending_q, pending_d;

  pwm_timebase #(
    .RESOLUTION(RESOLUTION),
    .PRESCALE_W(PRESCALE_W)
  ) u_timebase (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .enable_i  (enable_i),
    .mode_i    (mode_i),
    .period_i  (period_i),
    .prescale_i(prescale_i),
    .count_o   (count),
    .commit_o  (commit),
    .period_o  (period_o)
  );

  assign wr_valid = wr_en_i && (32'(wr_ch_i) < CHANNELS);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [RESOLUTION-1:0] shadow_q, shadow_d;
    logic [RESOLUTION-1:0] active_q, active_d;

    // Commit reads the old shadow, so a write on a boundary waits a full period.
    always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (commit) begin
        active_d = shadow_q;
      end
      if (wr_valid && 32'(wr_ch_i) == c) begin
        shadow_d = wr_duty_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!reset_n) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end

    assign out_d[c] = enable_i & (count < active_q);
  end

  always_comb begin
    pending_d = pending_q;
    if (commit) begin
      pending_d = 1'b0;
    end
    if (wr_valid) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      out_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      pending_q <= pending_d;
    end
  end

  assign out_o     = out_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi against a phase-indexed period model.
module tb_pwm_multi;

  localparam int CH  = 4;
  localparam int RES = 12;
  localparam int PW  = 8;
  localparam int WCH = 2;

  logic            clk_i = 1'b0;
  logic            reset_n;
  logic            enable_i;
  logic            mode_i;
  logic [RES-1:0]  period_i;
  logic [PW-1:0]   prescale_i;
  logic            wr_en_i;
  logic [WCH-1:0]  wr_ch_i;
  logic [RES-1:0]  wr_duty_i;
  logic [CH-1:0]   out_o;
  logic            period_o;
  logic            pending_o;

  int checks = 0;
  int errors = 0;

  // Model: position in the period as a tick index plus clocks within the tick.
  int m_phase, m_sub, m_per, m_mode, m_pre;
  int m_active[CH];
  int m_shadow[CH];
  bit m_pending, m_start;
  logic [CH-1:0] exp_out;
  logic          exp_per;

  pwm_multi #(.CHANNELS(CH), .RESOLUTION(RES), .PRESCALE_W(PW)) dut (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .enable_i  (enable_i),
    .mode_i    (mode_i),
    .period_i  (period_i),
    .prescale_i(prescale_i),
    .wr_en_i   (wr_en_i),
    .wr_ch_i   (wr_ch_i),
    .wr_duty_i (wr_duty_i),
    .out_o     (out_o),
    .period_o  (period_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int m_len();
    if (m_mode == 0 || m_per == 0) return m_per + 1;
    return 2 * m_per;
  endfunction

  function automatic int m_value();
    if (m_mode == 0 || m_per == 0) return m_phase;
    return (m_phase <= m_per) ? m_phase : 2 * m_per - m_phase;
  endfunction

  function automatic bit at_boundary();
    return enable_i && (m_sub == m_pre) && (m_phase == m_len() - 1);
  endfunction

  task automatic step();
    bit commit;
    if (!reset_n) begin
      exp_out = '0;
      exp_per = 1'b0;
      m_phase = 0; m_sub = 0; m_per = 0; m_mode = 0; m_pre = 0;
      m_pending = 0; m_start = 0;
      for (int c = 0; c < CH; c++) begin
        m_active[c] = 0;
        m_shadow[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) exp_out[c] = enable_i && (m_value() < m_active[c]);
      exp_per = enable_i && m_start;
      commit = 0;
      if (!enable_i) begin
        m_phase = 0; m_sub = 0; m_start = 1; commit = 1;
      end else begin
        int len;
        len = m_len();
        m_start = 0;
        if (m_sub == m_pre) begin
          m_sub = 0;
          m_phase++;
          if (m_phase >= len) begin
            m_phase = 0; m_start = 1; commit = 1;
          end
        end else begin
          m_sub++;
        end
      end
      if (commit) begin
        m_per  = int'(period_i);
        m_mode = int'(mode_i);
        m_pre  = int'(prescale_i);
        for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
        m_pending = 0;
      end
      if (wr_en_i && int'(wr_ch_i) < CH) begin
        m_shadow[int'(wr_ch_i)] = int'(wr_duty_i);
        m_pending = 1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int ch, input int duty);
    wr_en_i   = 1'b1;
    wr_ch_i   = WCH'(ch);
    wr_duty_i = RES'(duty);
    step();
    wr_en_i   = 1'b0;
  endtask

  task automatic configure(input bit mode, input int per, input int pre);
    enable_i   = 1'b0;
    mode_i     = mode;
    period_i   = RES'(per);
    prescale_i = PW'(pre);
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if (out_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset out_o: got %b want 0000", out_o); end
    checks++;
    if (period_o !== 1'b0) begin errors++; $display("[TB] FAIL reset period_o: got %b want 0", period_o); end
    checks++;
    if (pending_o !== 1'b0) begin errors++; $display("[TB] FAIL reset pending_o: got %b want 0", pending_o); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_edge();
    int hi[CH];
    int pulses = 0;
    configure(1'b0, 9, 0);
    applyStimulus(0, 3);
    applyStimulus(1, 0);
    applyStimulus(2, 10);
    applyStimulus(3, 5);
    step();
    for (int c = 0; c < CH; c++) hi[c] = 0;
    enable_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (out_o !== exp_out) begin errors++; $display("[TB] FAIL edge out_o cyc %0d: got %b want %b", i, out_o, exp_out); end
      checks++;
      if (period_o !== exp_per) begin errors++; $display("[TB] FAIL edge period_o cyc %0d: got %b want %b", i, period_o, exp_per); end
      for (int c = 0; c < CH; c++) hi[c] += int'(out_o[c]);
      pulses += int'(period_o);
    end
    checks++;
    if (hi[0] != 9) begin errors++; $display("[TB] FAIL edge ch0 high count: got %0d want 9", hi[0]); end
    checks++;
    if (hi[1] != 0) begin errors++; $display("[TB] FAIL edge ch1 high count: got %0d want 0", hi[1]); end
    checks++;
    if (hi[2] != 30) begin errors++; $display("[TB] FAIL edge ch2 high count: got %0d want 30", hi[2]); end
    checks++;
    if (hi[3] != 15) begin errors++; $display("[TB] FAIL edge ch3 high count: got %0d want 15", hi[3]); end
    checks++;
    if (pulses != 3) begin errors++; $display("[TB] FAIL edge period_o count: got %0d want 3", pulses); end
  endtask

  task automatic test_center();
    int hi = 0;
    int pulses = 0;
    logic [7:0] pat;
    configure(1'b1, 4, 0);
    applyStimulus(0, 2);
    step();
    enable_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if (out_o !== exp_out) begin errors++; $display("[TB] FAIL center out_o cyc %0d: got %b want %b", i, out_o, exp_out); end
      checks++;
      if (period_o !== exp_per) begin errors++; $display("[TB] FAIL center period_o cyc %0d: got %b want %b", i, period_o, exp_per); end
      if (i < 8) pat[i] = out_o[0];
      hi += int'(out_o[0]);
      pulses += int'(period_o);
    end
    checks++;
    if (pat !== 8'b1000_0011) begin errors++; $display("[TB] FAIL center ch0 pattern: got %b want 10000011", pat); end
    checks++;
    if (hi != 12) begin errors++; $display("[TB] FAIL center ch0 high count: got %0d want 12", hi); end
    checks++;
    if (pulses != 4) begin errors++; $display("[TB] FAIL center period_o count: got %0d want 4", pulses); end
  endtask

  task automatic test_prescale();
    int hi = 0;
    int pulses = 0;
    configure(1'b0, 3, 2);
    applyStimulus(0, 2);
    step();
    enable_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (out_o !== exp_out) begin errors++; $display("[TB] FAIL prescale out_o cyc %0d: got %b want %b", i, out_o, exp_out); end
      checks++;
      if (period_o !== exp_per) begin errors++; $display("[TB] FAIL prescale period_o cyc %0d: got %b want %b", i, period_o, exp_per); end
      hi += int'(out_o[0]);
      pulses += int'(period_o);
    end
    checks++;
    if (hi != 12) begin errors++; $display("[TB] FAIL prescale ch0 high count: got %0d want 12", hi); end
    checks++;
    if (pulses != 2) begin errors++; $display("[TB] FAIL prescale period_o count: got %0d want 2", pulses); end
  endtask

  task automatic test_midwrite();
    int hi;
    bit found = 0;
    configure(1'b0, 15, 0);
    applyStimulus(1, 3);
    step();
    enable_i = 1'b1;
    repeat (5) step();
    applyStimulus(1, 7);
    checks++;
    if (pending_o !== 1'b1) begin errors++; $display("[TB] FAIL midwrite pending_o: got %b want 1", pending_o); end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (out_o !== exp_out) begin errors++; $display("[TB] FAIL midwrite out_o cyc %0d: got %b want %b", i, out_o, exp_out); end
      checks++;
      if (pending_o !== logic'(m_pending)) begin errors++; $display("[TB] FAIL midwrite pending_o cyc %0d: got %b want %b", i, pending_o, m_pending); end
    end
    for (int i = 0; i < 40 && !found; i++) begin
      if (at_boundary()) found = 1;
      else step();
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL midwrite boundary wait: got timeout want boundary"); end
    applyStimulus(1, 12);
    checks++;
    if (pending_o !== 1'b1) begin errors++; $display("[TB] FAIL boundary-write pending_o: got %b want 1", pending_o); end
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (out_o !== exp_out) begin errors++; $display("[TB] FAIL boundary-write out_o cyc %0d: got %b want %b", i, out_o, exp_out); end
      hi += int'(out_o[1]);
    end
    checks++;
    if (hi != 7) begin errors++; $display("[TB] FAIL boundary-write old duty count: got %0d want 7", hi); end
    checks++;
    if (pending_o !== 1'b0) begin errors++; $display("[TB] FAIL boundary-write pending after commit: got %b want 0", pending_o); end
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      hi += int'(out_o[1]);
    end
    checks++;
    if (hi != 12) begin errors++; $display("[TB] FAIL boundary-write new duty count: got %0d want 12", hi); end
  endtask

  task automatic test_enable_toggle();
    repeat (7) step();
    enable_i = 1'b0;
    step();
    checks++;
    if (out_o !== 4'b0000) begin errors++; $display("[TB] FAIL disable out_o: got %b want 0000", out_o); end
    applyStimulus(2, 4);
    step();
    enable_i = 1'b1;
    step();
    checks++;
    if (period_o !== 1'b1) begin errors++; $display("[TB] FAIL reenable period_o: got %b want 1", period_o); end
    checks++;
    if (out_o[2] !== 1'b1) begin errors++; $display("[TB] FAIL reenable ch2 at count 0: got %b want 1", out_o[2]); end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (out_o !== exp_out) begin errors++; $display("[TB] FAIL reenable out_o cyc %0d: got %b want %b", i, out_o, exp_out); end
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    if (out_o !== exp_out) begin errors++; $display("[TB] FAIL %s out_o: got %b want %b", tag, out_o, exp_out); end
    checks++;
    if (period_o !== exp_per) begin errors++; $display("[TB] FAIL %s period_o: got %b want %b", tag, period_o, exp_per); end
    checks++;
    if (pending_o !== logic'(m_pending)) begin errors++; $display("[TB] FAIL %s pending_o: got %b want %b", tag, pending_o, m_pending); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(0, 9);
    repeat (3) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if (out_o !== 4'b0000) begin errors++; $display("[TB] FAIL midreset out_o: got %b want 0000", out_o); end
    checks++;
    if (pending_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset pending_o: got %b want 0", pending_o); end
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("post-reset");
    end
  endtask

  task automatic test_random();
    configure(1'b0, 5, 0);
    enable_i = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) enable_i = ~enable_i;
      if ($urandom_range(0, 24) == 0) begin
        period_i   = RES'($urandom_range(0, 12));
        mode_i     = 1'($urandom_range(0, 1));
        prescale_i = PW'($urandom_range(0, 2));
      end
      wr_en_i   = ($urandom_range(0, 7) == 0);
      wr_ch_i   = WCH'($urandom_range(0, CH - 1));
      wr_duty_i = RES'($urandom_range(0, 14));
      step();
      checkOutput("random");
    end
    wr_en_i = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    enable_i   = 1'b0;
    mode_i     = 1'b0;
    period_i   = '0;
    prescale_i = '0;
    wr_en_i    = 1'b0;
    wr_ch_i    = '0;
    wr_duty_i  = '0;
    #2;
    test_reset();
    test_edge();
    test_center();
    test_prescale();
    test_midwrite();
    test_enable_toggle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
